// File: rtl/mdu_ctrl_pkg.sv
// Shared operation codes, FSM state encoding and decode helpers for the
// multiply/divide unit controller.
package mdu_ctrl_pkg;

    typedef enum logic [2:0] {
        MDU_OP_NONE  = 3'd0,
        MDU_OP_MULT  = 3'd1,
        MDU_OP_MULTU = 3'd2,
        MDU_OP_DIV   = 3'd3,
        MDU_OP_DIVU  = 3'd4,
        MDU_OP_MTHI  = 3'd5,
        MDU_OP_MTLO  = 3'd6
    } mduOp_e;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_MULT = 2'd1,
        MDU_DIV  = 2'd2
    } mduState_e;

    function automatic logic isMultOp(input mduOp_e op);
        return (op == MDU_OP_MULT) || (op == MDU_OP_MULTU);
    endfunction

    function automatic logic isDivOp(input mduOp_e op);
        return (op == MDU_OP_DIV) || (op == MDU_OP_DIVU);
    endfunction

endpackage

// File: rtl/mdu_ctrl.sv
// E-stage multiply/divide controller: owns HI/LO, runs fixed-latency
// mult/div sequences and raises stall while a result is outstanding.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MDU_i_Start,
    input  logic [2:0]  MDU_i_Op,
    input  logic [31:0] MDU_i_A,
    input  logic [31:0] MDU_i_B,
    output logic        MDU_o_Busy,
    output logic        MDU_o_Stall,
    output logic [31:0] MDU_o_Hi,
    output logic [31:0] MDU_o_Lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    mduState_e          state, stateNext;
    logic [CNT_W-1:0]   cnt, cntNext;
    logic [31:0]        hiReg, hiNext, loReg, loNext;
    logic [31:0]        pendHi, pendHiNext, pendLo, pendLoNext;
    logic               pendValid, pendValidNext;

    mduOp_e             op;
    logic               opIsMult, opIsDiv, opIsSigned, divByZero;
    logic signed [63:0] aExt, bExt, product;
    logic [31:0]        quotient, remainder;

    assign op         = mduOp_e'(MDU_i_Op);
    assign opIsMult   = isMultOp(op);
    assign opIsDiv    = isDivOp(op);
    assign opIsSigned = (op == MDU_OP_MULT) || (op == MDU_OP_DIV);
    assign divByZero  = (MDU_i_B == 32'd0);

    // Widening to 64 bits lets one signed multiplier/divider serve both
    // signednesses and makes 0x80000000 / -1 wrap naturally to 0x80000000.
    assign aExt    = opIsSigned ? {{32{MDU_i_A[31]}}, MDU_i_A} : {32'd0, MDU_i_A};
    assign bExt    = opIsSigned ? {{32{MDU_i_B[31]}}, MDU_i_B} : {32'd0, MDU_i_B};
    assign product = aExt * bExt;

    assign quotient  = divByZero ? 32'd0 : 32'(aExt / bExt);
    assign remainder = divByZero ? 32'd0 : 32'(aExt % bExt);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= MDU_IDLE;
            cnt       <= '0;
            hiReg     <= '0;
            loReg     <= '0;
            pendHi    <= '0;
            pendLo    <= '0;
            pendValid <= 1'b0;
        end else begin
            state     <= stateNext;
            cnt       <= cntNext;
            hiReg     <= hiNext;
            loReg     <= loNext;
            pendHi    <= pendHiNext;
            pendLo    <= pendLoNext;
            pendValid <= pendValidNext;
        end
    end

    // Starts are only honoured in IDLE; a divide by zero runs the full
    // latency but leaves nothing valid to commit.
    always_comb begin
        stateNext     = state;
        cntNext       = cnt;
        hiNext        = hiReg;
        loNext        = loReg;
        pendHiNext    = pendHi;
        pendLoNext    = pendLo;
        pendValidNext = pendValid;

        case (state)
            MDU_IDLE: begin
                if (MDU_i_Start) begin
                    if (opIsMult) begin
                        pendHiNext    = product[63:32];
                        pendLoNext    = product[31:0];
                        pendValidNext = 1'b1;
                        cntNext       = CNT_W'(MULT_CYCLES);
                        stateNext     = MDU_MULT;
                    end else if (opIsDiv) begin
                        pendHiNext    = remainder;
                        pendLoNext    = quotient;
                        pendValidNext = !divByZero;
                        cntNext       = CNT_W'(DIV_CYCLES);
                        stateNext     = MDU_DIV;
                    end else if (op == MDU_OP_MTHI) begin
                        hiNext = MDU_i_A;
                    end else if (op == MDU_OP_MTLO) begin
                        loNext = MDU_i_A;
                    end
                end
            end
            MDU_MULT, MDU_DIV: begin
                if (cnt == CNT_W'(1)) begin
                    if (pendValid) begin
                        hiNext = pendHi;
                        loNext = pendLo;
                    end
                    pendValidNext = 1'b0;
                    cntNext       = '0;
                    stateNext     = MDU_IDLE;
                end else begin
                    cntNext = cnt - CNT_W'(1);
                end
            end
            default: begin
                stateNext = MDU_IDLE;
                cntNext   = '0;
            end
        endcase
    end

    assign MDU_o_Busy  = (state != MDU_IDLE);
    assign MDU_o_Stall = MDU_o_Busy | (MDU_i_Start & (opIsMult | opIsDiv));
    assign MDU_o_Hi    = hiReg;
    assign MDU_o_Lo    = loReg;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed, table-driven bench for mdu_ctrl with hand-computed HI/LO,
// latency and stall expectations plus reset and back-to-back sequences.
module tb_mdu_ctrl;
    import mdu_ctrl_pkg::*;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        mduStart;
    logic [2:0]  mduOp;
    logic [31:0] mduA, mduB;
    logic        mduBusy, mduStall;
    logic [31:0] mduHi, mduLo;

    int errors = 0;
    int checks = 0;

    typedef struct {
        mduOp_e      op;
        logic [31:0] a;
        logic [31:0] b;
        int          expStall;
        int          expCycles;
        logic [31:0] expHi;
        logic [31:0] expLo;
    } vec_t;

    vec_t vecs[10];

    mdu_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk         (clk),
        .reset       (reset),
        .MDU_i_Start (mduStart),
        .MDU_i_Op    (mduOp),
        .MDU_i_A     (mduA),
        .MDU_i_B     (mduB),
        .MDU_o_Busy  (mduBusy),
        .MDU_o_Stall (mduStall),
        .MDU_o_Hi    (mduHi),
        .MDU_o_Lo    (mduLo)
    );

    always #5 clk = ~clk;

    // The hazard unit never issues into a busy unit; flag it if the bench does.
    always @(posedge clk) begin
        if (!reset) begin
            assert (!(mduStart && mduBusy))
                else $error("[TB] FAIL start-while-busy: start=%0b busy=%0b", mduStart, mduBusy);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Issues one op for a single cycle, then scrambles the operands and
    // counts busy cycles until the unit is idle again (bounded).
    task automatic applyStimulus(input mduOp_e op, input logic [31:0] a, input logic [31:0] b,
                                 output int startStall, output int cycles, output int stallDrops);
        mduStart = 1'b1;
        mduOp    = op;
        mduA     = a;
        mduB     = b;
        #1;
        startStall = int'(mduStall);
        @(posedge clk); #1;
        mduStart   = 1'b0;
        mduOp      = MDU_OP_NONE;
        mduA       = $urandom;
        mduB       = $urandom;
        cycles     = 0;
        stallDrops = 0;
        while (mduBusy && cycles < 64) begin
            if (!mduStall) stallDrops++;
            @(posedge clk); #1;
            cycles++;
        end
    endtask

    initial begin
        int startStall, cycles, stallDrops;

        vecs[0] = '{MDU_OP_MULT,  32'hFFFFFFFF, 32'd2,        1, MULT_N, 32'hFFFFFFFF, 32'hFFFFFFFE};
        vecs[1] = '{MDU_OP_MULTU, 32'hFFFFFFFF, 32'd2,        1, MULT_N, 32'h00000001, 32'hFFFFFFFE};
        vecs[2] = '{MDU_OP_DIV,   32'hFFFFFFF9, 32'd2,        1, DIV_N,  32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3] = '{MDU_OP_DIVU,  32'd7,        32'd2,        1, DIV_N,  32'h00000001, 32'h00000003};
        vecs[4] = '{MDU_OP_DIV,   32'h80000000, 32'hFFFFFFFF, 1, DIV_N,  32'h00000000, 32'h80000000};
        vecs[5] = '{MDU_OP_MTHI,  32'h00001234, 32'd0,        0, 0,      32'h00001234, 32'h80000000};
        vecs[6] = '{MDU_OP_MTLO,  32'h00005678, 32'd0,        0, 0,      32'h00001234, 32'h00005678};
        vecs[7] = '{MDU_OP_DIV,   32'd5,        32'd0,        1, DIV_N,  32'h00001234, 32'h00005678};
        vecs[8] = '{MDU_OP_MTHI,  32'hDEADBEEF, 32'd0,        0, 0,      32'hDEADBEEF, 32'h00005678};
        vecs[9] = '{MDU_OP_MULT,  32'd3,        32'hFFFFFFFC, 1, MULT_N, 32'hFFFFFFFF, 32'hFFFFFFF4};

        reset    = 1'b1;
        mduStart = 1'b0;
        mduOp    = MDU_OP_NONE;
        mduA     = '0;
        mduB     = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        checkOutput("reset busy",  32'(mduBusy),  32'd0);
        checkOutput("reset stall", 32'(mduStall), 32'd0);
        checkOutput("reset hi",    mduHi,         32'd0);
        checkOutput("reset lo",    mduLo,         32'd0);
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, startStall, cycles, stallDrops);
            checkOutput($sformatf("vec%0d start stall", i), 32'(startStall), 32'(vecs[i].expStall));
            checkOutput($sformatf("vec%0d busy cycles", i), 32'(cycles), 32'(vecs[i].expCycles));
            checkOutput($sformatf("vec%0d stall drops", i), 32'(stallDrops), 32'd0);
            checkOutput($sformatf("vec%0d idle stall", i), 32'(mduStall), 32'd0);
            checkOutput($sformatf("vec%0d hi", i), mduHi, vecs[i].expHi);
            checkOutput($sformatf("vec%0d lo", i), mduLo, vecs[i].expLo);
        end

        // Back-to-back: second MULT issued in the first non-busy cycle.
        applyStimulus(MDU_OP_MULT, 32'd6, 32'd7, startStall, cycles, stallDrops);
        checkOutput("b2b first cycles", 32'(cycles), 32'(MULT_N));
        checkOutput("b2b first lo",     mduLo,       32'd42);
        checkOutput("b2b first hi",     mduHi,       32'd0);
        applyStimulus(MDU_OP_MULTU, 32'h00010000, 32'h00010000, startStall, cycles, stallDrops);
        checkOutput("b2b second stall",  32'(startStall), 32'd1);
        checkOutput("b2b second cycles", 32'(cycles),     32'(MULT_N));
        checkOutput("b2b second hi",     mduHi,           32'd1);
        checkOutput("b2b second lo",     mduLo,           32'd0);

        // Reset asserted in the fourth busy cycle of a divide.
        mduStart = 1'b1;
        mduOp    = MDU_OP_DIVU;
        mduA     = 32'd100;
        mduB     = 32'd7;
        @(posedge clk); #1;
        mduStart = 1'b0;
        mduOp    = MDU_OP_NONE;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("mid-div busy", 32'(mduBusy), 32'd1);
        reset = 1'b1;
        #1;
        checkOutput("async reset busy",  32'(mduBusy),  32'd0);
        checkOutput("async reset stall", 32'(mduStall), 32'd0);
        checkOutput("async reset hi",    mduHi,         32'd0);
        checkOutput("async reset lo",    mduLo,         32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        checkOutput("post reset busy", 32'(mduBusy), 32'd0);
        checkOutput("post reset hi",   mduHi,        32'd0);
        checkOutput("post reset lo",   mduLo,        32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
